draw_text_box: RTL
==================

Name: draw_text_box

Overview:
- Parametrised text-overlay stage for the VGA pipeline. Draws a TEXT_COLS x TEXT_ROWS grid of font cells at a runtime-programmable screen position.
- Fetches character codes from an external synchronous text RAM and glyph rows from an external synchronous font ROM, then muxes foreground/background colour over the incoming rgb stream.
- Sits between the background/rectangle stages and the VGA output register; all timing signals leave delayed by the same fixed latency as rgb.

Parameters:
- TEXT_COLS, 16, characters per row; power of two, 1..128.
- TEXT_ROWS, 16, character rows; power of two, 1..64.
- CHAR_W, 8, glyph width in pixels; must equal the char_pixel width.
- CHAR_H, 16, glyph height in pixels; power of two.
- CODE_W, 7, character code width used in the font address.
- FG_RGB, 12'h000, foreground colour.
- BG_RGB, 12'hFFF, background colour when bg_opaque=1.

Ports:
- pclk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  overlay enable; sampled at frame start.
- xpos  in  12  box left edge; sampled at frame start.
- ypos  in  12  box top edge; sampled at frame start.
- bg_opaque  in  1  1 = paint BG_RGB on 0-pixels, 0 = transparent; sampled at frame start.
- hcount_in, vcount_in  in  12 each  timing counters.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes.
- rgb_in  in  12  incoming pixel colour.
- char_xy  out  log2(TEXT_COLS)+log2(TEXT_ROWS)  text RAM address {row, col}.
- char_code  in  CODE_W  text RAM data; valid 1 cycle after char_xy.
- font_addr  out  CODE_W+log2(CHAR_H)  font ROM address {char_code, line}.
- char_pixel  in  CHAR_W  font ROM data; valid 1 cycle after font_addr.
- hcount_out, vcount_out  out  12 each  timing counters delayed by LAT.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  timing strobes delayed by LAT.
- rgb_out  out  12  overlaid colour.

Behaviour:
- Reset: while rst_n=0, every output is 0, including char_xy, font_addr and the shadow registers. Release is synchronous to the next pclk edge.
- Shadow registers: xpos, ypos, enable and bg_opaque are copied into shadow registers only in the cycle where hcount_in==0 and vcount_in==0. A mid-frame change has no effect until the next frame. After reset, shadow enable=0.
- Stage 0 (input cycle):
  - dx = hcount_in - xs, dy = vcount_in - ys, computed as 12-bit unsigned wrap.
  - in_box = (hcount_in >= xs) && (dx < TEXT_COLS*CHAR_W) && (vcount_in >= ys) && (dy < TEXT_ROWS*CHAR_H).
  - char_xy <= {dy/CHAR_H, dx/CHAR_W}, registered. char_xy is driven regardless of in_box.
- Stage 1: font_addr <= {char_code, line}, where line = dy mod CHAR_H carried from stage 0.
- Stage 2: bit index b = CHAR_W-1-(dx mod CHAR_W), carried forward; the MSB of char_pixel is the leftmost pixel.
- Stage 3: rgb_out and timing outputs are registered.
  - If the delayed hblnk or vblnk is set, or in_box=0, or shadow enable=0: rgb_out = delayed rgb_in.
  - Else if char_pixel[b]=1: rgb_out = FG_RGB.
  - Else: rgb_out = BG_RGB when bg_opaque=1, otherwise delayed rgb_in.
- Latency: LAT = 4 cycles, inputs to all *_out. in_box, b and rgb are pipelined alongside.
- Boundaries:
  - Box clipped at the right/bottom screen edge: no wrap to the left side.
  - xpos+width beyond 4095: pixels past counter wrap are outside the box.
  - Box fully off-screen: pure passthrough.
- Reset asserted mid-line: outputs go to 0 immediately; the pipeline refills within LAT cycles after release.

Optional Feature:
- DRAW_TEXT_CURSOR_EN.
- Defined:
  - Extra inputs cursor_col and cursor_row (widths match the char_xy fields), sampled with the other shadow registers.
  - A 6-bit frame counter increments at each frame start; reset value 0.
  - While counter bit 5 = 1, the cell at (cursor_row, cursor_col) is drawn with FG and BG swapped; a transparent background reads as FG_RGB.
- Undefined: no cursor ports, no counter, behaviour exactly as above.

Decomposition:
- Package draw_text_pkg: LAT, address-width helper constants (COL_W, ROW_W, LINE_W) and the default colour constants.
- Sub-module: the existing delay module carries the timing bundle {hcount, hsync, hblnk, vcount, vsync, vblnk} and rgb for LAT-1 cycles before the output register.

Test Plan:
- Reset: hold rst_n=0 mid-frame -> all outputs 0. Release -> rgb_out follows rgb_in 4 cycles later.
- Addressing: xpos=100, ypos=50, enable=1. Pixel at (108,67) -> char_xy={row 1, col 1} one cycle later. char_code=7'h41 -> font_addr={7'h41, 4'd1}.
- Glyph draw: char_pixel=8'h80. Pixel x=100 -> rgb_out=FG_RGB. x=101 with bg_opaque=0 -> rgb_in passthrough; with bg_opaque=1 -> BG_RGB.
- Edges: x=99, x=228, y=49 and y=306 -> passthrough. Any pixel with hblnk=1 inside the box -> passthrough.
- Shadow timing: change xpos 100->200 at vcount=300 -> current frame still uses 100; next frame starts at x=200. Same check for enable toggling.
- Cursor (DRAW_TEXT_CURSOR_EN): cursor=(0,0), glyph 8'h80. Frames 32-63 -> pixel (100,50)=BG_RGB and (101,50)=FG_RGB. Frames 0-31 -> normal colours.

Source files
------------

// File: rtl/draw_text_pkg.sv
// Shared constants for the draw_text_box text-overlay stage: pipeline
// latency, address-field widths for the default 16x16 grid of 8x16 glyphs,
// the default overlay colours and an address-width helper.
package draw_text_pkg;

    // Cycles from any *_in to the matching *_out.
    localparam int LAT = 4;

    // Address field widths for the default geometry (16 cols, 16 rows, 16 lines).
    localparam int COL_W  = 4;
    localparam int ROW_W  = 4;
    localparam int LINE_W = 4;

    // Default overlay colours: black glyphs on a white box.
    localparam logic [11:0] DEF_FG_RGB = 12'h000;
    localparam logic [11:0] DEF_BG_RGB = 12'hFFF;

    // Width of an index into n items, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/draw_text_box_delay.sv
// Fixed-length register pipeline. Carries the timing bundle and rgb
// alongside the text lookup so that every output leaves aligned.
module draw_text_box_delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_r [CLK_DEL];

    // Shift the bundle one stage per clock; reset flushes every stage to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLK_DEL; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[CLK_DEL-1];

endmodule

// File: rtl/draw_text_box.sv
// Text-overlay stage for the VGA pipeline. Draws a TEXT_COLS x TEXT_ROWS
// grid of glyphs at a position latched at frame start, looking character
// codes up in an external text RAM and glyph rows in an external font ROM.
// The char_xy and font_addr registers act as the memories' address
// registers: char_code and char_pixel are consumed in the cycle after the
// respective address register updates. Output latency is LAT = 4 cycles.
// Optional build macro DRAW_TEXT_CURSOR_EN adds a blinking cursor cell.
module draw_text_box
    import draw_text_pkg::*;
#(
    parameter int          TEXT_COLS = 16,
    parameter int          TEXT_ROWS = 16,
    parameter int          CHAR_W    = 8,
    parameter int          CHAR_H    = 16,
    parameter int          CODE_W    = 7,
    parameter logic [11:0] FG_RGB    = DEF_FG_RGB,
    parameter logic [11:0] BG_RGB    = DEF_BG_RGB,
    localparam int         CW        = addr_w(TEXT_COLS),
    localparam int         RW        = addr_w(TEXT_ROWS),
    localparam int         LW        = addr_w(CHAR_H),
    localparam int         PW        = addr_w(CHAR_W)
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [11:0]          xpos,
    input  logic [11:0]          ypos,
    input  logic                 bg_opaque,
`ifdef DRAW_TEXT_CURSOR_EN
    input  logic [CW-1:0]        cursor_col,
    input  logic [RW-1:0]        cursor_row,
`endif
    input  logic [11:0]          hcount_in,
    input  logic [11:0]          vcount_in,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 hblnk_in,
    input  logic                 vblnk_in,
    input  logic [11:0]          rgb_in,
    output logic [RW+CW-1:0]     char_xy,
    input  logic [CODE_W-1:0]    char_code,
    output logic [CODE_W+LW-1:0] font_addr,
    input  logic [CHAR_W-1:0]    char_pixel,
    output logic [11:0]          hcount_out,
    output logic [11:0]          vcount_out,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 hblnk_out,
    output logic                 vblnk_out,
    output logic [11:0]          rgb_out
);

    localparam logic [12:0] BOX_W = 13'(TEXT_COLS * CHAR_W);
    localparam logic [12:0] BOX_H = 13'(TEXT_ROWS * CHAR_H);
    localparam int          BUNDLE_W = 40;

    logic [11:0]   xs_r, ys_r;
    logic          en_r, opq_r;
    logic          frame_start_s;
    logic [11:0]   dx_s, dy_s;
    logic          in_box_s;
    logic          draw0_r, draw1_r, draw2_r;
    logic          opq0_r, opq1_r, opq2_r;
    logic          cur0_r, cur1_r, cur2_r;
    logic [LW-1:0] line0_r;
    logic [PW-1:0] bidx0_r, bidx1_r;
    logic          pix2_r;
    logic [11:0]   rgb_next_s;

    logic [BUNDLE_W-1:0] bundle_in_s, bundle_d_s;
    logic [11:0]   hcount_d_s, vcount_d_s, rgb_d_s;
    logic          hsync_d_s, vsync_d_s, hblnk_d_s, vblnk_d_s;

    // Box-relative coordinates and the membership test for the incoming pixel.
    always_comb begin
        frame_start_s = (hcount_in == 12'd0) && (vcount_in == 12'd0);
        dx_s          = hcount_in - xs_r;
        dy_s          = vcount_in - ys_r;
        in_box_s      = (hcount_in >= xs_r) && ({1'b0, dx_s} < BOX_W) &&
                        (vcount_in >= ys_r) && ({1'b0, dy_s} < BOX_H);
    end

    // Latch position, enable and opacity only at the first pixel of a frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            xs_r  <= 12'd0;
            ys_r  <= 12'd0;
            en_r  <= 1'b0;
            opq_r <= 1'b0;
        end else if (frame_start_s) begin
            xs_r  <= xpos;
            ys_r  <= ypos;
            en_r  <= enable;
            opq_r <= bg_opaque;
        end
    end

`ifdef DRAW_TEXT_CURSOR_EN
    logic [5:0]    frame_cnt_r;
    logic [CW-1:0] cur_col_r;
    logic [RW-1:0] cur_row_r;

    // Count frames for the blink and latch the cursor cell with the shadows.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 6'd0;
            cur_col_r   <= '0;
            cur_row_r   <= '0;
        end else if (frame_start_s) begin
            frame_cnt_r <= frame_cnt_r + 6'd1;
            cur_col_r   <= cursor_col;
            cur_row_r   <= cursor_row;
        end
    end
`endif

    // Stage 0: issue the text RAM address and capture the per-pixel context.
    // The bit index assumes CHAR_W is a power of two (MSB is leftmost pixel).
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            char_xy <= '0;
            draw0_r <= 1'b0;
            opq0_r  <= 1'b0;
            cur0_r  <= 1'b0;
            line0_r <= '0;
            bidx0_r <= '0;
        end else begin
            char_xy <= {dy_s[LW +: RW], dx_s[PW +: CW]};
            draw0_r <= in_box_s && en_r;
            opq0_r  <= opq_r;
`ifdef DRAW_TEXT_CURSOR_EN
            cur0_r  <= frame_cnt_r[5] && (dy_s[LW +: RW] == cur_row_r) &&
                       (dx_s[PW +: CW] == cur_col_r);
`else
            cur0_r  <= 1'b0;
`endif
            line0_r <= dy_s[LW-1:0];
            bidx0_r <= ~dx_s[PW-1:0];
        end
    end

    // Stage 1: combine the fetched character code with the glyph line.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            font_addr <= '0;
            draw1_r   <= 1'b0;
            opq1_r    <= 1'b0;
            cur1_r    <= 1'b0;
            bidx1_r   <= '0;
        end else begin
            font_addr <= {char_code, line0_r};
            draw1_r   <= draw0_r;
            opq1_r    <= opq0_r;
            cur1_r    <= cur0_r;
            bidx1_r   <= bidx0_r;
        end
    end

    // Stage 2: pick this pixel's bit out of the fetched glyph row.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix2_r  <= 1'b0;
            draw2_r <= 1'b0;
            opq2_r  <= 1'b0;
            cur2_r  <= 1'b0;
        end else begin
            pix2_r  <= char_pixel[bidx1_r];
            draw2_r <= draw1_r;
            opq2_r  <= opq1_r;
            cur2_r  <= cur1_r;
        end
    end

    assign bundle_in_s = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in};

    draw_text_box_delay #(
        .WIDTH   (BUNDLE_W),
        .CLK_DEL (LAT - 1)
    ) u_delay (
        .clk   (pclk),
        .rst_n (rst_n),
        .din   (bundle_in_s),
        .dout  (bundle_d_s)
    );

    assign {hcount_d_s, hsync_d_s, hblnk_d_s, vcount_d_s, vsync_d_s, vblnk_d_s, rgb_d_s} = bundle_d_s;

    // Colour select: blanking or outside the box passes rgb through; a cursor
    // cell swaps the colours and shows FG even where the box is transparent.
    always_comb begin
        rgb_next_s = rgb_d_s;
        if (hblnk_d_s || vblnk_d_s || !draw2_r) begin
            rgb_next_s = rgb_d_s;
        end else if (cur2_r) begin
            rgb_next_s = pix2_r ? BG_RGB : FG_RGB;
        end else if (pix2_r) begin
            rgb_next_s = FG_RGB;
        end else if (opq2_r) begin
            rgb_next_s = BG_RGB;
        end else begin
            rgb_next_s = rgb_d_s;
        end
    end

    // Stage 3: output register for colour and the delayed timing bundle.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= 12'd0;
            vcount_out <= 12'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= hcount_d_s;
            vcount_out <= vcount_d_s;
            hsync_out  <= hsync_d_s;
            vsync_out  <= vsync_d_s;
            hblnk_out  <= hblnk_d_s;
            vblnk_out  <= vblnk_d_s;
            rgb_out    <= rgb_next_s;
        end
    end

endmodule
